// File: rtl/mb32_hw_bridge.sv
// 32-bit memory-bus slave that serves each word access as two back-to-back
// 16-bit half-word accesses (low half, then high half) to a synchronous RAM.
module mb32_hw_bridge #(
  parameter int DSZ = 32,
  parameter int ASZ = 15,
  parameter int MSZ = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           we,
  input  logic [3:0]     bmsk,
  input  logic [ASZ-1:0] ai,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] vo,
  output logic           rdy,
  output logic           busy,
  output logic           m_cs,
  output logic           m_we,
  output logic [ASZ:0]   m_a,
  output logic [3:0]     m_msk,
  output logic [MSZ-1:0] m_di,
  input  logic [MSZ-1:0] m_do,
  output logic [1:0]     dbg_state_o
);

  // Handshake: req is sampled only while idle (busy=0); requests seen while
  // busy are dropped. Each accepted request ends with rdy high for exactly
  // one cycle, three edges after the accepting edge; vo is valid with rdy.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic           we_q, we_d;
  logic [3:0]     msk_q, msk_d;
  logic [ASZ-1:0] a_q, a_d;
  logic [DSZ-1:0] d_q, d_d;
  logic [MSZ-1:0] lo_q, lo_d;
  logic [DSZ-1:0] vo_q, vo_d;
  logic           rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    msk_d   = msk_q;
    a_d     = a_q;
    d_d     = d_q;
    lo_d    = lo_q;
    vo_d    = vo_q;
    rdy_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          msk_d   = bmsk;
          a_d     = ai;
          d_d     = vi;
          state_d = S_LO;
        end
      end
      S_LO: state_d = S_HI;
      S_HI: begin
        lo_d    = m_do;
        state_d = S_FIN;
      end
      S_FIN: begin
        if (!we_q) vo_d = {m_do, lo_q};
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Each byte-lane enable covers the two nibbles of that byte in the half.
  always_comb begin
    m_cs  = 1'b0;
    m_we  = 1'b0;
    m_a   = '0;
    m_msk = 4'b0000;
    m_di  = '0;
    case (state_q)
      S_LO: begin
        m_cs  = 1'b1;
        m_we  = we_q & (|msk_q[1:0]);
        m_a   = {a_q, 1'b0};
        m_msk = {msk_q[1], msk_q[1], msk_q[0], msk_q[0]};
        m_di  = d_q[MSZ-1:0];
      end
      S_HI: begin
        m_cs  = 1'b1;
        m_we  = we_q & (|msk_q[3:2]);
        m_a   = {a_q, 1'b1};
        m_msk = {msk_q[3], msk_q[3], msk_q[2], msk_q[2]};
        m_di  = d_q[DSZ-1:MSZ];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      msk_q   <= 4'b0000;
      a_q     <= '0;
      d_q     <= '0;
      lo_q    <= '0;
      vo_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      msk_q   <= msk_d;
      a_q     <= a_d;
      d_q     <= d_d;
      lo_q    <= lo_d;
      vo_q    <= vo_d;
      rdy_q   <= rdy_d;
    end
  end

  assign vo          = vo_q;
  assign rdy         = rdy_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mb32_hw_bridge.sv
// Bench for mb32_hw_bridge: a 16-bit RAM model behind the bridge, a word-level
// transaction model checked every cycle, plus directed literal expectations.
module tb_mb32_hw_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  bmsk = 4'h0;
  logic [14:0] ai = '0;
  logic [31:0] vi = '0;
  logic [31:0] vo;
  logic        rdy, busy, m_cs, m_we;
  logic [15:0] m_a;
  logic [3:0]  m_msk;
  logic [15:0] m_di;
  logic [15:0] m_do = '0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mb32_hw_bridge dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .bmsk(bmsk), .ai(ai), .vi(vi),
    .vo(vo), .rdy(rdy), .busy(busy), .m_cs(m_cs), .m_we(m_we), .m_a(m_a),
    .m_msk(m_msk), .m_di(m_di), .m_do(m_do), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // 16-bit synchronous RAM with nibble write mask; read data one cycle later.
  logic [15:0] mem [int];
  always @(posedge clk) begin
    logic [15:0] w;
    if (m_cs) begin
      w = mem.exists(int'(m_a)) ? mem[int'(m_a)] : 16'h0000;
      if (m_we) begin
        for (int i = 0; i < 4; i++)
          if (m_msk[i]) w[4*i +: 4] = m_di[4*i +: 4];
        mem[int'(m_a)] = w;
      end
      m_do <= w;
    end
  end

  // Word-level reference: a transaction accepted at edge S occupies the bus
  // for the cycles after edges S..S+2 and completes in the cycle after S+3.
  logic [31:0] ref_mem [int];
  int          cyc = 0;
  int          t_start = -1000;
  logic        t_we = 1'b0;
  logic [3:0]  t_m = 4'h0;
  logic [14:0] t_a = '0;
  logic [31:0] t_v = '0;
  logic [31:0] t_rd = '0;
  logic [31:0] vo_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] old;
    if (!rst_n) begin
      t_start = -1000;
      vo_exp  = 32'h0;
    end else begin
      cyc++;
      if (cyc - t_start == 3 && !t_we) vo_exp = t_rd;
      if (cyc - t_start >= 4 && req) begin
        t_start = cyc;
        t_we = we; t_m = bmsk; t_a = ai; t_v = vi;
        old = ref_mem.exists(int'(ai)) ? ref_mem[int'(ai)] : 32'h0;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (bmsk[b]) old[8*b +: 8] = vi[8*b +: 8];
          ref_mem[int'(ai)] = old;
        end else begin
          t_rd = old;
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    int          d;
    logic [1:0]  half_m;
    logic [3:0]  e_msk;
    logic [15:0] e_a, e_di;
    logic        e_cs, e_we;
    if (rst_n === 1'b1) begin
      d      = cyc - t_start;
      e_cs   = (d == 0) || (d == 1);
      half_m = (d == 0) ? t_m[1:0] : (d == 1) ? t_m[3:2] : 2'b00;
      for (int i = 0; i < 4; i++) e_msk[i] = e_cs ? half_m[i/2] : 1'b0;
      e_a    = e_cs ? {t_a, (d == 1)} : 16'h0;
      e_di   = (d == 0) ? t_v[15:0] : (d == 1) ? t_v[31:16] : 16'h0;
      e_we   = e_cs && t_we && (half_m != 2'b00);
      chk("m_cs", 32'(m_cs), 32'(e_cs));
      chk("m_we", 32'(m_we), 32'(e_we));
      chk("m_a", 32'(m_a), 32'(e_a));
      chk("m_msk", 32'(m_msk), 32'(e_msk));
      chk("m_di", 32'(m_di), 32'(e_di));
      chk("busy", 32'(busy), 32'(d >= 0 && d <= 2));
      chk("rdy", 32'(rdy), 32'(d == 3));
      chk("vo", vo, vo_exp);
    end
  end

  // driver
  logic [15:0] cap_lo_a, cap_hi_a;
  logic [3:0]  cap_lo_msk, cap_hi_msk;
  logic        cap_lo_we, cap_hi_we;

  task automatic txn(input logic w, input logic [3:0] m, input logic [14:0] a,
                     input logic [31:0] v, input bit noise);
    int got_k;
    @(negedge clk);
    we = w; bmsk = m; ai = a; vi = v; req = 1'b1;
    got_k = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin cap_lo_a = m_a; cap_lo_msk = m_msk; cap_lo_we = m_we; end
      if (k == 1) begin cap_hi_a = m_a; cap_hi_msk = m_msk; cap_hi_we = m_we; end
      if (rdy && got_k < 0) got_k = k;
      if (noise && k <= 2 && got_k < 0) begin
        req = 1'b1; ai = a ^ 15'h1555; we = ~w; vi = ~v; bmsk = ~m;
      end else begin
        req = 1'b0;
      end
      if (got_k >= 0) break;
    end
    req = 1'b0;
    chk("rdy_latency", 32'(got_k), 32'd3);
  endtask

  logic [31:0] rv;
  int          npulse, first_k, last_k;

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_vo", vo, 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_m_cs", 32'(m_cs), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // read aborted by reset while in the high half
    @(negedge clk); we = 1'b0; ai = 15'h0010; bmsk = 4'hF; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("hi_rst_busy", 32'(busy), 32'h0);
    chk("hi_rst_m_cs", 32'(m_cs), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    npulse = 0;
    repeat (6) begin @(negedge clk); if (rdy) npulse++; end
    chk("hi_rst_no_rdy", 32'(npulse), 32'd0);
    chk("hi_rst_vo", vo, 32'h0);

    // top address
    rv = $urandom;
    txn(1'b1, 4'hF, 15'h7FFF, rv, 1'b0);
    txn(1'b0, 4'h0, 15'h7FFF, 32'h0, 1'b0);
    chk("top_lo_a", 32'(cap_lo_a), 32'h0000FFFE);
    chk("top_hi_a", 32'(cap_hi_a), 32'h0000FFFF);
    chk("top_vo", vo, rv);

    // full write then read
    txn(1'b1, 4'hF, 15'h0123, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 4'hF, 15'h0123, 32'h0, 1'b0);
    chk("fw_lo_a", 32'(cap_lo_a), 32'h00000246);
    chk("fw_hi_a", 32'(cap_hi_a), 32'h00000247);
    chk("fw_vo", vo, 32'hDEADBEEF);

    // asynchronous reset mid-cycle during a read clears vo at once
    @(negedge clk); we = 1'b0; ai = 15'h0123; req = 1'b1;
    @(negedge clk); req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vo", vo, 32'h0);
    chk("arst_rdy", 32'(rdy), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_m_cs", 32'(m_cs), 32'h0);
    chk("arst_m_we", 32'(m_we), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // byte-masked write
    txn(1'b1, 4'hF, 15'h0040, 32'h11223344, 1'b0);
    txn(1'b1, 4'b0101, 15'h0040, 32'hAABBCCDD, 1'b0);
    chk("bm_lo_msk", 32'(cap_lo_msk), 32'h3);
    chk("bm_hi_msk", 32'(cap_hi_msk), 32'h3);
    chk("bm_lo_we", 32'(cap_lo_we), 32'h1);
    chk("bm_hi_we", 32'(cap_hi_we), 32'h1);
    txn(1'b0, 4'h0, 15'h0040, 32'h0, 1'b0);
    chk("bm_vo", vo, 32'h11BB33DD);

    // low half skipped
    txn(1'b1, 4'hF, 15'h0050, 32'h55667788, 1'b0);
    txn(1'b1, 4'b1100, 15'h0050, 32'h99AABBCC, 1'b0);
    chk("hs_lo_we", 32'(cap_lo_we), 32'h0);
    chk("hs_hi_we", 32'(cap_hi_we), 32'h1);
    chk("hs_hi_msk", 32'(cap_hi_msk), 32'hF);
    txn(1'b0, 4'h0, 15'h0050, 32'h0, 1'b0);
    chk("hs_vo", vo, 32'h99AA7788);

    // req toggled while busy is ignored
    txn(1'b0, 4'hF, 15'h0123, 32'h0, 1'b1);
    chk("busy_hi_a", 32'(cap_hi_a), 32'h00000247);
    chk("busy_vo", vo, 32'hDEADBEEF);

    // req held high: one completion every 4 cycles
    @(negedge clk); we = 1'b0; ai = 15'h0040; req = 1'b1;
    npulse = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rdy) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        npulse++;
      end
    end
    req = 1'b0;
    chk("b2b_count", 32'(npulse), 32'd4);
    chk("b2b_first", 32'(first_k), 32'd3);
    chk("b2b_last", 32'(last_k), 32'd15);
    repeat (4) @(negedge clk);

    // randomized traffic over a small address pool
    for (int n = 0; n < 150; n++) begin
      logic [14:0] ra;
      case ($urandom_range(0, 9))
        8:       ra = 15'h7FFF;
        9:       ra = 15'h7FFE;
        default: ra = 15'($urandom_range(0, 7));
      endcase
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom,
          ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
